// File: rtl/pulse_capture.sv
// Measures high time and period of an asynchronous pulse waveform in Clk50 cycles.
// A synchronizer and history flop feed a three-state measurement FSM with saturating count and timeout.
module pulse_capture #(
  parameter logic [31:0] TIMEOUT     = 32'd10000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        Clk50,
  input  logic        Reset,
  input  logic        Input,
  output logic [31:0] HighCount,
  output logic [31:0] PeriodCount,
  output logic        Valid,
  output logic        Timeout,
  output logic        Busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   sync_s;
  logic                   rise_s;
  logic                   fall_s;

  state_e      state_q,        state_d;
  logic [31:0] count_q,        count_d;
  logic [31:0] count_inc_s;
  logic [31:0] high_latch_q,   high_latch_d;
  logic [31:0] high_count_q,   high_count_d;
  logic [31:0] period_count_q, period_count_d;
  logic        valid_q,        valid_d;
  logic        timeout_q,      timeout_d;
  logic        busy_q,         busy_d;

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign rise_s = sync_s & ~hist_q;
  assign fall_s = ~sync_s & hist_q;

  // Input synchronizer chain followed by the edge-detect history flop
  always_ff @(posedge Clk50 or posedge Reset) begin
    if (Reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], Input};
      hist_q <= sync_s;
    end
  end

  assign count_inc_s = (count_q == COUNT_MAX) ? count_q : (count_q + 32'd1);

  // Measurement FSM next-state; an edge always wins over an expiring timeout
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    high_latch_d   = high_latch_q;
    high_count_d   = high_count_q;
    period_count_d = period_count_q;
    valid_d        = 1'b0;
    timeout_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise_s) begin
          state_d = ST_HIGH;
          count_d = 32'd1;
        end else begin
          count_d = count_q;
        end
      end
      ST_HIGH: begin
        if (fall_s) begin
          high_latch_d = count_q;
          count_d      = count_inc_s;
          state_d      = ST_LOW;
        end else if (count_q == TIMEOUT) begin
          state_d   = ST_IDLE;
          count_d   = 32'd0;
          timeout_d = 1'b1;
        end else begin
          count_d = count_inc_s;
        end
      end
      ST_LOW: begin
        if (rise_s) begin
          period_count_d = count_q;
          high_count_d   = high_latch_q;
          valid_d        = 1'b1;
          count_d        = 32'd1;
          state_d        = ST_HIGH;
        end else if (count_q == TIMEOUT) begin
          state_d   = ST_IDLE;
          count_d   = 32'd0;
          timeout_d = 1'b1;
        end else begin
          count_d = count_inc_s;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = 32'd0;
      end
    endcase
    busy_d = (state_d == ST_HIGH) || (state_d == ST_LOW);
  end

  // FSM, counters and registered outputs
  always_ff @(posedge Clk50 or posedge Reset) begin
    if (Reset) begin
      state_q        <= ST_IDLE;
      count_q        <= 32'd0;
      high_latch_q   <= 32'd0;
      high_count_q   <= 32'd0;
      period_count_q <= 32'd0;
      valid_q        <= 1'b0;
      timeout_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      high_latch_q   <= high_latch_d;
      high_count_q   <= high_count_d;
      period_count_q <= period_count_d;
      valid_q        <= valid_d;
      timeout_q      <= timeout_d;
      busy_q         <= busy_d;
    end
  end

  assign HighCount   = high_count_q;
  assign PeriodCount = period_count_q;
  assign Valid       = valid_q;
  assign Timeout     = timeout_q;
  assign Busy        = busy_q;

endmodule

// File: tb/tb_pulse_capture.sv
// Self-checking bench for pulse_capture: vector table, corner sequences, and random
// waveforms compared every cycle against a timestamp-based reference model.
module tb_pulse_capture;
  localparam int          N   = 2;
  localparam int          TOI = 1000;
  localparam logic [31:0] TO  = 32'd1000;

  logic        Clk50 = 1'b0;
  logic        Reset;
  logic        Input;
  logic [31:0] HighCount;
  logic [31:0] PeriodCount;
  logic        Valid;
  logic        Timeout;
  logic        Busy;

  pulse_capture #(.TIMEOUT(TO), .SYNC_STAGES(N)) dut (
    .Clk50(Clk50), .Reset(Reset), .Input(Input),
    .HighCount(HighCount), .PeriodCount(PeriodCount),
    .Valid(Valid), .Timeout(Timeout), .Busy(Busy)
  );

  always #5 Clk50 = ~Clk50;

  int tests = 0;
  int fails = 0;

  // Reference model: raw samples since reset plus timestamps of the last edges
  logic        raw_q[$];
  int          k;
  bit          m_active;
  int          m_trise, m_tfall;
  logic [31:0] m_hc, m_pc;
  bit          m_valid, m_to;
  int          valid_seen = 0;
  int          timeout_seen = 0;
  int          obs_h[$];
  int          obs_p[$];

  typedef struct {
    int high;
    int low;
    int exp_h;
    int exp_p;
  } vec_t;
  vec_t tbl[9];

  function automatic logic get_raw(int i);
    if (i < 1 || i > raw_q.size()) return 1'b0;
    return raw_q[i-1];
  endfunction

  function automatic void model_clear();
    raw_q.delete();
    k = 0; m_active = 0; m_trise = 0; m_tfall = 0;
    m_hc = 32'd0; m_pc = 32'd0; m_valid = 0; m_to = 0;
  endfunction

  // Decision cycle D sees the synchronized value that was sampled N edges before its end
  function automatic void model_cycle();
    int   d;
    logic s, p;
    d = k - 1;
    s = get_raw(k - N);
    p = get_raw(k - N - 1);
    m_valid = 0;
    m_to = 0;
    if (!m_active) begin
      if (s && !p) begin m_active = 1; m_trise = d; end
    end else if (s && !p) begin
      m_valid = 1;
      m_hc = 32'(m_tfall - m_trise);
      m_pc = 32'(d - m_trise);
      m_trise = d;
    end else if (!s && p) begin
      m_tfall = d;
    end else if (d - m_trise == TOI) begin
      m_to = 1;
      m_active = 0;
    end
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic v);
    Input = v;
    @(posedge Clk50);
    #1;
    k++;
    raw_q.push_back(v);
    model_cycle();
    tests++;
    if (HighCount !== m_hc || PeriodCount !== m_pc || Valid !== m_valid ||
        Timeout !== m_to || Busy !== m_active) begin
      fails++;
      $display("FAIL model k=%0d: got H=%0d P=%0d V=%b T=%b B=%b, expected H=%0d P=%0d V=%b T=%b B=%b",
               k, HighCount, PeriodCount, Valid, Timeout, Busy,
               m_hc, m_pc, m_valid, m_to, m_active);
    end
    if (Valid === 1'b1) begin
      valid_seen++;
      obs_h.push_back(int'(HighCount));
      obs_p.push_back(int'(PeriodCount));
    end
    if (Timeout === 1'b1) timeout_seen++;
  endtask

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  task automatic check_zero(input string name);
    tests++;
    if (HighCount !== 32'd0 || PeriodCount !== 32'd0 || Valid !== 1'b0 ||
        Timeout !== 1'b0 || Busy !== 1'b0) begin
      fails++;
      $display("FAIL %s: got H=%0d P=%0d V=%b T=%b B=%b, expected all 0",
               name, HighCount, PeriodCount, Valid, Timeout, Busy);
    end
  endtask

  // Asynchronous reset mid-cycle, then release away from the clock edge
  task automatic do_reset(input logic in_val, input string name);
    #2;
    Reset = 1'b1;
    Input = in_val;
    #1;
    check_zero(name);
    repeat (2) @(posedge Clk50);
    #3;
    Reset = 1'b0;
    model_clear();
  endtask

  initial begin
    int lat, busy_k, to_k, vs, ts, rises, first_rises;
    logic [31:0] hc0, pc0;
    bit found;

    Reset = 1'b1;
    Input = 1'b0;
    model_clear();
    #1;
    check_zero("reset_state");
    repeat (2) @(posedge Clk50);
    #3;
    Reset = 1'b0;

    tbl[0] = '{50, 150, 50, 200};
    tbl[1] = '{50, 150, 50, 200};
    tbl[2] = '{50, 150, 50, 200};
    tbl[3] = '{150, 50, 150, 200};
    tbl[4] = '{1, 9, 1, 10};
    tbl[5] = '{1, 9, 1, 10};
    tbl[6] = '{1, 1, 1, 2};
    tbl[7] = '{500, 499, 500, 999};
    tbl[8] = '{600, 400, 600, 1000};

    drive(1'b0, 5);
    obs_h.delete();
    obs_p.delete();
    foreach (tbl[i]) begin
      drive(1'b1, tbl[i].high);
      drive(1'b0, tbl[i].low);
    end
    drive(1'b1, N + 5);
    check("table_valid_count", obs_h.size(), 9);
    foreach (tbl[i]) begin
      if (i < obs_h.size()) begin
        check($sformatf("table[%0d].HighCount", i), obs_h[i], tbl[i].exp_h);
        check($sformatf("table[%0d].PeriodCount", i), obs_p[i], tbl[i].exp_p);
      end
    end

    // Input-to-Valid latency, counting the cycle in which Input rises
    drive(1'b0, 20);
    lat = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b1);
      lat++;
      if (Valid === 1'b1) found = 1;
    end
    check("valid_seen_latency", found, 1);
    check("latency", lat, N + 2);
    drive(1'b1, 5);

    // Long low phase abandons the measurement, then a single rise held high
    ts = timeout_seen;
    drive(1'b0, 1100);
    check("timeout_from_low", timeout_seen - ts, 1);
    check("busy_after_low_timeout", Busy, 0);
    hc0 = m_hc;
    pc0 = m_pc;
    vs = valid_seen;
    ts = timeout_seen;
    busy_k = -1;
    to_k = -1;
    for (int i = 0; i < 1500; i++) begin
      step(1'b1);
      if (Busy === 1'b1 && busy_k < 0) busy_k = k;
      if (Timeout === 1'b1) to_k = k;
    end
    check("held_high_timeouts", timeout_seen - ts, 1);
    check("held_high_no_valid", valid_seen - vs, 0);
    check("timeout_delay", to_k - busy_k, TOI);
    check("held_high_busy_dropped", Busy, 0);
    check("held_high_HighCount_kept", HighCount, hc0);
    check("held_high_PeriodCount_kept", PeriodCount, pc0);
    drive(1'b0, 20);

    // Reset during the low phase discards the measurement
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 50);
      drive(1'b0, 150);
    end
    drive(1'b1, 50);
    drive(1'b0, 60);
    do_reset(1'b0, "reset_mid_low");
    vs = valid_seen;
    rises = 0;
    first_rises = -1;
    for (int i = 0; i < 3; i++) begin
      rises++;
      for (int j = 0; j < 50; j++) begin
        step(1'b1);
        if (valid_seen != vs && first_rises < 0) first_rises = rises;
      end
      for (int j = 0; j < 150; j++) begin
        step(1'b0);
        if (valid_seen != vs && first_rises < 0) first_rises = rises;
      end
    end
    check("rises_before_first_valid", first_rises, 2);
    check("post_reset_HighCount", HighCount, 50);
    check("post_reset_PeriodCount", PeriodCount, 200);

    // Random waveforms, including a release with Input already high
    for (int i = 0; i < 60; i++) begin
      int h, l;
      h = int'($urandom_range(1, 300));
      l = int'($urandom_range(1, 300));
      if ($urandom_range(0, 7) == 0) h = int'($urandom_range(900, 1100));
      if ($urandom_range(0, 7) == 0) l = int'($urandom_range(900, 1100));
      if (i == 30) begin
        do_reset(1'b1, "reset_input_high");
        vs = valid_seen;
        drive(1'b1, N + 2);
        check("rise_at_release_busy", Busy, 1);
        check("rise_at_release_no_valid", valid_seen - vs, 0);
      end
      drive(1'b1, h);
      drive(1'b0, l);
    end
    drive(1'b1, N + 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
